word_serializer: RTL and testbench
==================================

Name: word_serializer

Overview:
- Downstream consumer of the single-entry mailbox fifo (ports `full`, `read_strobe`, `read_data`).
- Pops one DATA_BUS_WIDTH word whenever the mailbox reports full.
- Shifts the word out on a bit-serial clock/data pair and pulses a latch after every WORDS_PER_LATCH words.
- Drives daisy-chained shift-register loads (LED drivers, expanders) from the system clock domain.

Parameters:
- DATA_BUS_WIDTH, 16, word width; must match the mailbox; >=2.
- CLOCK_DIVIDER, 4, clk cycles per sclk half-period (low half and high half each); >=1.
- WORDS_PER_LATCH, 1, words shifted between latch pulses; >=1.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- fifo_full  input  1  mailbox `full` flag; a word is waiting.
- read_strobe  output  1  one-cycle pop to mailbox `read_strobe`.
- read_data  input  DATA_BUS_WIDTH  mailbox `read_data`; valid the cycle after read_strobe.
- sclk  output  1  serial clock; data sampled by receiver on rising edge.
- sdata  output  1  serial data.
- latch  output  1  load pulse, high for CLOCK_DIVIDER cycles.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- All outputs are registered. Reset value of read_strobe, sclk, sdata, latch and busy is 0.
- Reset also clears state to IDLE and zeroes the shift register, bit counter, divider counter and word counter.
- States: IDLE, FETCH, SHIFT_LO, SHIFT_HI, LATCH.
- IDLE:
  - if fifo_full=1, assert read_strobe for exactly one cycle and go to FETCH; else stay.
  - read_strobe is never asserted in any other state, so the mailbox cannot be underrun by this block.
- FETCH (one cycle): capture read_data into the shift register, clear bit counter, go to SHIFT_LO.
- SHIFT_LO:
  - sclk=0; sdata = current bit (MSB of shift register); hold CLOCK_DIVIDER cycles; go to SHIFT_HI.
  - sdata changes only on SHIFT_LO entry.
- SHIFT_HI:
  - sclk=1; hold CLOCK_DIVIDER cycles, then shift register left by 1 and increment bit counter.
  - If bit counter reaches DATA_BUS_WIDTH, the word is done; else go to SHIFT_LO.
- Word done:
  - if word counter = WORDS_PER_LATCH-1, clear word counter and go to LATCH;
  - else increment word counter and go to IDLE.
- LATCH: sclk=0, sdata=0, latch=1 for CLOCK_DIVIDER cycles, then IDLE.
- Idle output levels: sclk=0, sdata=0 in IDLE and FETCH.
- Per-word timing:
  - 2*CLOCK_DIVIDER*DATA_BUS_WIDTH shift cycles, plus 1 IDLE (strobe) cycle and 1 FETCH cycle.
  - Minimum 1 IDLE cycle between words.
- Back-to-back: if the mailbox refills during SHIFT/LATCH, it is not popped until IDLE. Upstream must respect mailbox full to avoid its fault.
- fifo_full deasserting between strobe and FETCH is irrelevant: FETCH always captures read_data.
- Reset mid-operation (any state):
  - next cycle all outputs 0, state IDLE, word counter 0.
  - The partial word is discarded; no latch pulse is generated for it.
- Counter widths: $clog2 of CLOCK_DIVIDER, DATA_BUS_WIDTH+1 and WORDS_PER_LATCH, minimum 1 bit.

Optional Feature:
- Macro: WORD_SERIALIZER_LSB_FIRST_EN.
- Defined: shift register shifts right and sdata = LSB, so bit 0 goes out first.
- Undefined: MSB first as above.
- Timing, latch and handshake are identical in both builds.

Test Plan:
- Reset: hold rst 3 cycles with fifo_full=1 -> read_strobe, sclk, sdata, latch, busy all 0 throughout; after release, read_strobe pulses exactly once.
- Single word (CLOCK_DIVIDER=2, WORDS_PER_LATCH=1): mailbox write 0xA5C3.
  - Exactly one read_strobe pulse.
  - sdata at 16 sclk rising edges = 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1.
  - Each sclk high 2 cycles, total 64 shift cycles.
  - Then latch high 2 cycles, then busy=0.
- Latch grouping (WORDS_PER_LATCH=2): write 0xFFFF then 0x0001 -> no latch after first word; latch pulse only after 32nd bit; second word last bit sdata=1.
- Back-to-back: write 0x1234 during shift of 0xA5C3 -> mailbox fault stays 0, second read_strobe occurs in first IDLE cycle after first word, second stream = 0x1234.
- Reset mid-shift after 7th sclk rise -> next cycle all outputs 0; next word written shifts all 16 bits from bit 15; latch count restarts at 0.
- WORD_SERIALIZER_LSB_FIRST_EN defined, write 0xA5C3 -> sdata sequence 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 with identical timing.

Source files
------------

// File: rtl/word_serializer_if.sv
// Mailbox pop handshake between the single-entry mailbox and word_serializer.
// master: the serializer (issues the pop); slave: the mailbox.
interface word_serializer_if #(
  parameter int unsigned DATA_BUS_WIDTH = 16
) ();
  logic                      fifo_full;
  logic                      read_strobe;
  logic [DATA_BUS_WIDTH-1:0] read_data;

  modport master (
    input  fifo_full,
    input  read_data,
    output read_strobe
  );

  modport slave (
    output fifo_full,
    output read_data,
    input  read_strobe
  );
endinterface

// File: rtl/word_serializer.sv
// Pops words from the mailbox and shifts them out on sclk/sdata, pulsing latch every
// WORDS_PER_LATCH words. Define WORD_SERIALIZER_LSB_FIRST_EN to send bit 0 first.
module word_serializer #(
  parameter int unsigned DATA_BUS_WIDTH  = 16,
  parameter int unsigned CLOCK_DIVIDER   = 4,
  parameter int unsigned WORDS_PER_LATCH = 1
) (
  input  logic              clk,
  input  logic              rst,
  word_serializer_if.master mbox,
  output logic              sclk,
  output logic              sdata,
  output logic              latch,
  output logic              busy
);

  localparam int unsigned DivW  = (CLOCK_DIVIDER > 1) ? $clog2(CLOCK_DIVIDER) : 1;
  localparam int unsigned BitW  = $clog2(DATA_BUS_WIDTH + 1);
  localparam int unsigned WordW = (WORDS_PER_LATCH > 1) ? $clog2(WORDS_PER_LATCH) : 1;

  localparam logic [DivW-1:0]  DivLast  = DivW'(CLOCK_DIVIDER - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_BUS_WIDTH - 1);
  localparam logic [WordW-1:0] WordLast = WordW'(WORDS_PER_LATCH - 1);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StShiftLo,
    StShiftHi,
    StLatch
  } state_e;

  state_e                    state_q;
  logic [DATA_BUS_WIDTH-1:0] shreg_q;
  logic [BitW-1:0]           bit_cnt_q;
  logic [DivW-1:0]           div_cnt_q;
  logic [WordW-1:0]          word_cnt_q;
  logic                      read_strobe_q;
  logic                      sclk_q;
  logic                      sdata_q;
  logic                      latch_q;
  logic                      busy_q;

  // Bit order selection: first bit taken from the fetched word, then the shifted register.
  logic [DATA_BUS_WIDTH-1:0] shreg_next;
  logic                      next_bit;
  logic                      first_bit;

  always_comb begin
`ifdef WORD_SERIALIZER_LSB_FIRST_EN
    shreg_next = shreg_q >> 1;
    next_bit   = shreg_q[1];
    first_bit  = mbox.read_data[0];
`else
    shreg_next = shreg_q << 1;
    next_bit   = shreg_q[DATA_BUS_WIDTH-2];
    first_bit  = mbox.read_data[DATA_BUS_WIDTH-1];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      shreg_q       <= '0;
      bit_cnt_q     <= '0;
      div_cnt_q     <= '0;
      word_cnt_q    <= '0;
      read_strobe_q <= 1'b0;
      sclk_q        <= 1'b0;
      sdata_q       <= 1'b0;
      latch_q       <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      read_strobe_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (mbox.fifo_full) begin
            read_strobe_q <= 1'b1;
            busy_q        <= 1'b1;
            state_q       <= StFetch;
          end
        end
        StFetch: begin
          shreg_q   <= mbox.read_data;
          bit_cnt_q <= '0;
          div_cnt_q <= '0;
          sclk_q    <= 1'b0;
          sdata_q   <= first_bit;
          state_q   <= StShiftLo;
        end
        StShiftLo: begin
          if (div_cnt_q == DivLast) begin
            div_cnt_q <= '0;
            sclk_q    <= 1'b1;
            state_q   <= StShiftHi;
          end else begin
            div_cnt_q <= div_cnt_q + DivW'(1);
          end
        end
        StShiftHi: begin
          if (div_cnt_q == DivLast) begin
            div_cnt_q <= '0;
            shreg_q   <= shreg_next;
            bit_cnt_q <= bit_cnt_q + BitW'(1);
            sclk_q    <= 1'b0;
            if (bit_cnt_q == BitLast) begin
              sdata_q <= 1'b0;
              if (word_cnt_q == WordLast) begin
                word_cnt_q <= '0;
                latch_q    <= 1'b1;
                state_q    <= StLatch;
              end else begin
                word_cnt_q <= word_cnt_q + WordW'(1);
                busy_q     <= 1'b0;
                state_q    <= StIdle;
              end
            end else begin
              // sdata only moves when a new low phase begins.
              sdata_q <= next_bit;
              state_q <= StShiftLo;
            end
          end else begin
            div_cnt_q <= div_cnt_q + DivW'(1);
          end
        end
        StLatch: begin
          if (div_cnt_q == DivLast) begin
            div_cnt_q <= '0;
            latch_q   <= 1'b0;
            busy_q    <= 1'b0;
            state_q   <= StIdle;
          end else begin
            div_cnt_q <= div_cnt_q + DivW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign mbox.read_strobe = read_strobe_q;
  assign sclk             = sclk_q;
  assign sdata            = sdata_q;
  assign latch            = latch_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_word_serializer.sv
// Scoreboard bench for word_serializer: a mailbox model feeds random and directed words,
// and a monitor rebuilds the serial stream and checks it against the queued expectations.
module tb_word_serializer;

  localparam int unsigned W   = 16;
  localparam int unsigned CD  = 2;
  localparam int unsigned WPL = 2;

  typedef struct {
    logic [W-1:0] word;
    bit           flag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sclk, sdata, latch, busy;

  logic         mb_full  = 1'b0;
  logic [W-1:0] mb_data  = '0;
  logic         mb_fault = 1'b0;
  logic         wr_req   = 1'b0;
  logic [W-1:0] wr_data  = '0;

  int   n_tests   = 0;
  int   n_fails   = 0;
  int   n_writes  = 0;
  int   n_strobes = 0;
  int   n_words   = 0;
  int   model_cnt = 0;
  exp_t exp_q[$];

  word_serializer_if #(.DATA_BUS_WIDTH(W)) mbox ();

  assign mbox.fifo_full = mb_full;
  assign mbox.read_data = mb_data;

  word_serializer #(
    .DATA_BUS_WIDTH (W),
    .CLOCK_DIVIDER  (CD),
    .WORDS_PER_LATCH(WPL)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .mbox (mbox),
    .sclk (sclk),
    .sdata(sdata),
    .latch(latch),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fails++;
    $display("FAIL %s: got timeout, expected completion", name);
  endtask

  // Serial bit i of word w, in transmission order.
  function automatic logic exp_bit(input logic [W-1:0] w, input int i);
`ifdef WORD_SERIALIZER_LSB_FIRST_EN
    return w[i];
`else
    return w[W-1-i];
`endif
  endfunction

  // Mailbox model: pop on strobe, load on write; expectation recorded when a word is popped.
  always @(posedge clk) begin
    exp_t e;
    if (rst) begin
      exp_q.delete();
      model_cnt = 0;
    end
    if (mbox.read_strobe) begin
      check("pop_nonempty", longint'(mb_full), 1);
      if (mb_full) begin
        e.word    = mb_data;
        e.flag    = (model_cnt == int'(WPL) - 1);
        model_cnt = e.flag ? 0 : model_cnt + 1;
        exp_q.push_back(e);
        mb_full <= 1'b0;
      end
    end
    if (wr_req) begin
      if (mb_full) mb_fault <= 1'b1;
      else begin
        mb_full <= 1'b1;
        mb_data <= wr_data;
      end
    end
  end

  // Monitor, sampling on the falling edge.
  initial begin
    bit   p_sclk, p_latch, p_busy, p_full, p_rst, p_strobe;
    bit   have_cur, done, done_now, lat_seen, lat_fall_now, pend;
    int   hi_run, lat_run, since_rise, since_strobe, bit_idx;
    exp_t cur;
    p_sclk = 0; p_latch = 0; p_busy = 0; p_full = 0; p_rst = 1; p_strobe = 0;
    have_cur = 0; done = 0; lat_seen = 0; pend = 0;
    hi_run = 0; lat_run = 0; since_rise = 0; since_strobe = 0; bit_idx = 0;
    cur.word = '0; cur.flag = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (p_rst) check("reset_outputs", {mbox.read_strobe, sclk, sdata, latch, busy}, 0);
        hi_run = 0; lat_run = 0; bit_idx = 0; done = 0; have_cur = 0;
      end else begin
        since_strobe++;
        since_rise++;
        done_now = 0;
        lat_fall_now = 0;
        if (!p_rst && !p_busy && p_full)
          check("strobe_latency", {busy, mbox.read_strobe}, 2'b11);
        if (mbox.read_strobe) begin
          check("strobe_width", p_strobe, 0);
          since_strobe = 0;
          n_strobes++;
        end
        if (sclk && !p_sclk) begin
          if (bit_idx == 0) begin
            if (exp_q.size() == 0) fail_now("no_expected_word");
            else begin
              cur = exp_q.pop_front();
              have_cur = 1;
            end
            check("first_rise_delay", since_strobe, CD + 1);
          end else begin
            check("rise_period", since_rise, 2 * CD);
          end
          since_rise = 0;
          bit_idx++;
        end
        if (sclk) begin
          hi_run++;
          if (have_cur) check("sdata_bit", sdata, exp_bit(cur.word, bit_idx - 1));
        end
        if (!sclk && p_sclk) begin
          check("sclk_high", hi_run, CD);
          hi_run = 0;
          if (bit_idx == W) begin
            bit_idx  = 0;
            done     = 1;
            done_now = 1;
            lat_seen = 0;
            have_cur = 0;
            pend     = cur.flag;
            n_words++;
          end
        end
        if (latch && !p_latch) begin
          check("latch_start", {done_now, pend}, 2'b11);
          lat_seen = 1;
        end
        if (latch) begin
          lat_run++;
          check("latch_quiet", {sclk, sdata}, 0);
        end
        if (!latch && p_latch) begin
          check("latch_len", lat_run, CD);
          lat_run = 0;
          lat_fall_now = 1;
        end
        if (!busy && p_busy) begin
          check("busy_fall", longint'((done_now && !pend) || lat_fall_now), 1);
          if (done) check("latch_grouping", lat_seen, pend);
          done = 0;
        end
        if (!busy) check("idle_quiet", {sclk, sdata, latch}, 0);
      end
      p_sclk = sclk; p_latch = latch; p_busy = busy; p_full = mb_full;
      p_rst = rst; p_strobe = mbox.read_strobe;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [W-1:0] d);
    int t = 0;
    while (mb_full && t < 3000) begin
      step();
      t++;
    end
    if (mb_full) fail_now("write_wait");
    else begin
      wr_req  = 1'b1;
      wr_data = d;
      step();
      wr_req  = 1'b0;
      n_writes++;
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((mb_full || busy || exp_q.size() != 0) && t < 3000) begin
      step();
      t++;
    end
    if (t >= 3000) fail_now("wait_idle");
    repeat (3) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rises;
    int t;
    bit p_s;
    // Reset held 3 cycles with the mailbox already full.
    rst     = 1'b1;
    wr_req  = 1'b1;
    wr_data = 16'hA5C3;
    step();
    wr_req = 1'b0;
    n_writes++;
    step();
    step();
    rst = 1'b0;
    wait_idle();

    write_word(16'hFFFF);
    write_word(16'h0001);
    wait_idle();

    // Second word arrives while the first is still shifting.
    write_word(16'hA5C3);
    repeat (10) step();
    write_word(16'h1234);
    wait_idle();

    // Reset after the 7th rising sclk of a word.
    write_word(16'h5A5A);
    rises = 0;
    t = 0;
    p_s = 0;
    while (rises < 7 && t < 2000) begin
      step();
      if (sclk && !p_s) rises++;
      p_s = sclk;
      t++;
    end
    if (rises < 7) fail_now("mid_shift_wait");
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    write_word(16'hC001);
    wait_idle();
    write_word(16'h8000);
    wait_idle();

    for (int i = 0; i < 24; i++) begin
      write_word(W'($urandom));
      repeat ($urandom_range(0, 90)) step();
    end
    wait_idle();

    check("mbox_fault", mb_fault, 0);
    check("strobe_count", n_strobes, n_writes);
    check("words_done", n_words, n_writes - 1);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule
